keypad_history_scanner: RTL

- Parametrised keypad front end: scans an R x C matrix, synchronises and debounces the column inputs, and emits one code per physical press (press-and-hold yields one event).
- Keeps the last HISTORY_DEPTH key codes in a shift history.
- Time-multiplexes that history onto a shared digit bus for an external seven-segment decoder.
- Successor to the fixed 4x4, two-digit keypad path, which runs from two divided clocks; this block runs entirely on the single system clock with internal tick counters.

---
 rtl/keypad_history_scanner.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/keypad_history_scanner.sv
// Scans an R x C keypad and debounces it, emitting one code per press.
// Keeps a shift history of recent codes and multiplexes it onto a digit bus.
module keypad_history_scanner #(
   parameter int NUM_ROWS        = 4,
   parameter int NUM_COLS        = 4,
   parameter int KEY_W           = 4,
   parameter int SCAN_DIV        = 100000,
   parameter int DEBOUNCE_CYCLES = 240000,
   parameter int HISTORY_DEPTH   = 2,
   parameter int DIGIT_DIV       = 50000
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_COLS-1:0]              cols,
   output logic [NUM_ROWS-1:0]              rows,
   output logic                             key_valid,
   output logic [KEY_W-1:0]                 key_code,
   output logic [HISTORY_DEPTH*KEY_W-1:0]   history,
   output logic [HISTORY_DEPTH-1:0]         digit_en,
   output logic [KEY_W-1:0]                 digit_value
);

   localparam int RowW  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam int ColW  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam int ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DbW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int DigW  = (DIGIT_DIV > 1) ? $clog2(DIGIT_DIV) : 1;
   localparam int HistW = HISTORY_DEPTH * KEY_W;

   typedef enum logic [1:0] {StScan, StPressDb, StHeld, StReleaseDb} state_e;

   state_e              state_q, state_d;
   logic [NUM_COLS-1:0] cols_meta_q, cols_sync_q;
   logic [RowW-1:0]     row_idx_q, row_idx_d;
   logic [ColW-1:0]     col_idx_q, col_idx_d;
   logic [ScanW-1:0]    scan_cnt_q, scan_cnt_d;
   logic [DbW-1:0]      db_cnt_q, db_cnt_d;
   logic                key_valid_q, key_valid_d;
   logic [KEY_W-1:0]    key_code_q, key_code_d;
   logic [HistW-1:0]    history_q, history_d;
   logic [DigW-1:0]     dig_cnt_q, dig_cnt_d;
   logic [HISTORY_DEPTH-1:0] digit_en_q, digit_en_d;

   logic            scan_tick, any_low, col_low, db_done, dig_wrap;
   logic [ColW-1:0] low_col;
   logic [RowW-1:0] row_next;
   logic [DbW-1:0]  db_inc;
   logic [KEY_W-1:0] new_code;

   always_comb begin
      scan_tick = (state_q == StScan) && (scan_cnt_q == ScanW'(SCAN_DIV - 1));
      any_low   = ~&cols_sync_q;
      col_low   = ~cols_sync_q[col_idx_q];
      db_inc    = db_cnt_q + DbW'(1);
      db_done   = (db_inc == DbW'(DEBOUNCE_CYCLES));
      row_next  = (row_idx_q == RowW'(NUM_ROWS - 1)) ? '0 : row_idx_q + RowW'(1);
      new_code  = KEY_W'(int'(row_idx_q) * NUM_COLS + int'(col_idx_q));
      // Descending scan so the lowest-index low column wins.
      low_col   = '0;
      for (int i = NUM_COLS - 1; i >= 0; i--) begin
         if (!cols_sync_q[i]) low_col = ColW'(i);
      end
   end

   always_comb begin
      state_d     = state_q;
      row_idx_d   = row_idx_q;
      col_idx_d   = col_idx_q;
      scan_cnt_d  = '0;
      db_cnt_d    = db_cnt_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;
      history_d   = history_q;
      unique case (state_q)
         StScan: begin
            db_cnt_d   = '0;
            scan_cnt_d = scan_tick ? '0 : scan_cnt_q + ScanW'(1);
            if (scan_tick) begin
               if (any_low) begin
                  col_idx_d = low_col;
                  state_d   = StPressDb;
               end else begin
                  row_idx_d = row_next;
               end
            end
         end
         StPressDb: begin
            if (!col_low) begin
               db_cnt_d = '0;
               state_d  = StScan;
            end else if (db_done) begin
               db_cnt_d    = '0;
               state_d     = StHeld;
               key_valid_d = 1'b1;
               key_code_d  = new_code;
               history_d   = (history_q << KEY_W) | HistW'(new_code);
            end else begin
               db_cnt_d = db_inc;
            end
         end
         StHeld: begin
            if (!col_low) begin
               db_cnt_d = '0;
               state_d  = StReleaseDb;
            end
         end
         StReleaseDb: begin
            if (col_low) begin
               db_cnt_d = '0;
               state_d  = StHeld;
            end else if (db_done) begin
               db_cnt_d  = '0;
               state_d   = StScan;
               row_idx_d = row_next;
            end else begin
               db_cnt_d = db_inc;
            end
         end
         default: state_d = StScan;
      endcase
   end

   always_comb begin
      dig_wrap   = (dig_cnt_q == DigW'(DIGIT_DIV - 1));
      dig_cnt_d  = dig_wrap ? '0 : dig_cnt_q + DigW'(1);
      digit_en_d = dig_wrap ? ((digit_en_q << 1) | (digit_en_q >> (HISTORY_DEPTH - 1)))
                            : digit_en_q;
      digit_value = '0;
      for (int k = 0; k < HISTORY_DEPTH; k++) begin
         if (digit_en_q[k]) digit_value = digit_value | history_q[k*KEY_W +: KEY_W];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StScan;
         cols_meta_q <= '1;
         cols_sync_q <= '1;
         row_idx_q   <= '0;
         col_idx_q   <= '0;
         scan_cnt_q  <= '0;
         db_cnt_q    <= '0;
         key_valid_q <= 1'b0;
         key_code_q  <= '0;
         history_q   <= '0;
         dig_cnt_q   <= '0;
         digit_en_q  <= HISTORY_DEPTH'(1);
      end else begin
         state_q     <= state_d;
         cols_meta_q <= cols;
         cols_sync_q <= cols_meta_q;
         row_idx_q   <= row_idx_d;
         col_idx_q   <= col_idx_d;
         scan_cnt_q  <= scan_cnt_d;
         db_cnt_q    <= db_cnt_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         history_q   <= history_d;
         dig_cnt_q   <= dig_cnt_d;
         digit_en_q  <= digit_en_d;
      end
   end

   assign rows      = ~(NUM_ROWS'(1) << row_idx_q);
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;
   assign history   = history_q;
   assign digit_en  = digit_en_q;

endmodule
